// File: rtl/pulse_meter_if.sv
// rtl/pulse_meter_if.sv - request/result handshake bundle for pulse_meter
//
// Purpose: groups the measurement request and result handshake signals.
// Signals:
//   Start     requester -> meter  one-cycle request to begin a measurement
//   Busy      meter -> requester  measurement in progress or result not yet taken
//   Valid     meter -> consumer   result available
//   Ready     consumer -> meter   result accepted when Valid && Ready
//   HighWidth meter -> consumer   cycles the waveform was high
//   Period    meter -> consumer   cycles between successive rising edges
//   TimedOut  meter -> consumer   measurement aborted by the phase timeout
// Modports: master = the meter, slave = requester/consumer side.
interface pulse_meter_if #(
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Busy;
  logic             Valid;
  logic             Ready;
  logic [CNT_W-1:0] HighWidth;
  logic [CNT_W-1:0] Period;
  logic             TimedOut;

  modport master (
    input  Start, Ready,
    output Busy, Valid, HighWidth, Period, TimedOut
  );

  modport slave (
    output Start, Ready,
    input  Busy, Valid, HighWidth, Period, TimedOut
  );
endinterface

// File: rtl/pulse_meter.sv
// rtl/pulse_meter.sv - single-cycle high-width / period meter for a digitised waveform
//
// Purpose: on each accepted Start, waits for a rising edge of In, then measures
// the high width and the period (rise to next rise) in Clk cycles and returns
// them over a valid/ready handshake. Each phase is bounded by TIMEOUT cycles.
// Ports:
//   Clk    clock, all state on rising edge
//   Rst_n  asynchronous active-low reset
//   In     asynchronous waveform under measurement
//   bus    pulse_meter_if.master (Start, Busy, Valid, Ready, HighWidth, Period, TimedOut)
// Optional feature macro: PULSE_METER_GLITCH_FILTER_EN
//   defined   : a GLITCH_CYC-cycle stability filter sits between the synchroniser
//               and the edge detector; shorter pulses are not seen
//   undefined : synchroniser output feeds edge detection directly
module pulse_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535,
  parameter int GLITCH_CYC  = 3
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          In,
  pulse_meter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    HIGH,
    LOW,
    DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   lvl;
  logic                   lvl_d;
  logic                   rise;
  logic                   fall;
  logic [CNT_W-1:0]       hcnt;
  logic [CNT_W-1:0]       pcnt;
  logic [CNT_W-1:0]       phcnt;
  logic                   phase_end;
  logic                   busy;
  logic                   valid;
  logic                   timed_out;

  // Input synchroniser; sync[0] is the metastability-exposed stage.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], In};
    end
  end

  assign s = sync[SYNC_STAGES-1];

`ifdef PULSE_METER_GLITCH_FILTER_EN
  localparam int GW = $clog2(GLITCH_CYC + 1);

  logic          f;
  logic [GW-1:0] gcnt;

  // f follows s only after s has disagreed with f for GLITCH_CYC cycles in a
  // row; returning to f's value restarts the count. Both edges see the same
  // delay, so measured widths are unaffected.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      f    <= 1'b0;
      gcnt <= '0;
    end else if (s == f) begin
      gcnt <= '0;
    end else if (gcnt == GW'(GLITCH_CYC - 1)) begin
      f    <= s;
      gcnt <= '0;
    end else begin
      gcnt <= gcnt + GW'(1);
    end
  end

  assign lvl = f;
`else
  logic unused_glitch_cyc;
  assign unused_glitch_cyc = (GLITCH_CYC != 0);
  assign lvl = s;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      lvl_d <= 1'b0;
    end else begin
      lvl_d <= lvl;
    end
  end

  assign rise      = lvl & ~lvl_d;
  assign fall      = ~lvl & lvl_d;
  // phcnt counts cycles already spent in the phase; this is the TIMEOUT-th.
  assign phase_end = (phcnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      hcnt      <= '0;
      pcnt      <= '0;
      phcnt     <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            state     <= ARM;
            busy      <= 1'b1;
            hcnt      <= '0;
            pcnt      <= '0;
            phcnt     <= '0;
            timed_out <= 1'b0;
          end
        end

        ARM: begin
          if (rise) begin
            state <= HIGH;
            hcnt  <= CNT_W'(1);
            pcnt  <= CNT_W'(1);
            phcnt <= '0;
          end else if (phase_end) begin
            state     <= DONE;
            timed_out <= 1'b1;
          end else begin
            phcnt <= phcnt + CNT_W'(1);
          end
        end

        HIGH: begin
          if (fall) begin
            // hcnt freezes here; the fall cycle already belongs to the low part.
            state <= LOW;
            pcnt  <= pcnt + CNT_W'(1);
            phcnt <= '0;
          end else if (phase_end) begin
            state     <= DONE;
            timed_out <= 1'b1;
          end else begin
            hcnt  <= hcnt + CNT_W'(1);
            pcnt  <= pcnt + CNT_W'(1);
            phcnt <= phcnt + CNT_W'(1);
          end
        end

        LOW: begin
          if (rise) begin
            state <= DONE;
          end else if (phase_end) begin
            state     <= DONE;
            timed_out <= 1'b1;
          end else begin
            // pcnt spans two timed phases, so saturate rather than wrap.
            if (pcnt != '1) begin
              pcnt <= pcnt + CNT_W'(1);
            end
            phcnt <= phcnt + CNT_W'(1);
          end
        end

        DONE: begin
          // Counters are not touched here, so the result holds under back-pressure.
          if (!valid) begin
            valid <= 1'b1;
          end else if (bus.Ready) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy      = busy;
  assign bus.Valid     = valid;
  assign bus.HighWidth = hcnt;
  assign bus.Period    = pcnt;
  assign bus.TimedOut  = timed_out;

endmodule
